// File: rtl/gpio_irq_if.sv
// Wishbone slave bundle for gpio_irq: 32-bit data, byte lanes, single-cycle ack.
interface gpio_irq_if;
    logic        cyc_i;
    logic        stb_i;
    logic [31:0] adr_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;

    modport master (
        output cyc_i, stb_i, adr_i, we_i, sel_i, dat_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  cyc_i, stb_i, adr_i, we_i, sel_i, dat_i,
        output dat_o, ack_o
    );
endinterface

// File: rtl/gpio_irq.sv
// gpio_irq: pin synchroniser, optional debounce, programmable edge detect,
// W1C event status and a level interrupt, behind a Wishbone slave.
// Optional feature macro: GPIO_IRQ_DEBOUNCE_EN builds the prescaler and
// debounce filter; without it the synchronised pins feed edge detect directly.
module gpio_irq #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DBNC_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    gpio_irq_if.slave        wb,
    input  logic [WIDTH-1:0] pin_i,
    output logic             irq_o
);
    localparam int unsigned BUS_W = 32;

    localparam logic [2:0] A_LEVEL   = 3'd0;
    localparam logic [2:0] A_RISE_EN = 3'd1;
    localparam logic [2:0] A_FALL_EN = 3'd2;
    localparam logic [2:0] A_STATUS  = 3'd3;
    localparam logic [2:0] A_DBNC    = 3'd4;

    logic             cs;
    logic             acc;
    logic             wr;
    logic [2:0]       reg_adr;
    logic [BUS_W-1:0] lane_mask;
    logic [BUS_W-1:0] rd_data;
    logic [BUS_W-1:0] dbnc_rd;
    logic             unused_adr;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] status;
    logic [WIDTH-1:0] set_bits;
    logic [WIDTH-1:0] clr_bits;

    // Bus decode: an access is taken on the edge that raises ack, so a held
    // strobe is served every other cycle.
    assign cs         = wb.cyc_i & wb.stb_i;
    assign acc        = cs & ~wb.ack_o;
    assign wr         = acc & wb.we_i;
    assign reg_adr    = wb.adr_i[4:2];
    assign unused_adr = ^{wb.adr_i[31:5], wb.adr_i[1:0]};

    // Expand byte-lane selects to a bit mask.
    always_comb begin
        lane_mask = {{8{wb.sel_i[3]}}, {8{wb.sel_i[2]}},
                     {8{wb.sel_i[1]}}, {8{wb.sel_i[0]}}};
    end

    // Two-flop synchroniser on the raw pins.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1 <= '0;
            sync  <= '0;
        end else begin
            sync1 <= pin_i;
            sync  <= sync1;
        end
    end

`ifdef GPIO_IRQ_DEBOUNCE_EN
    logic [DBNC_W-1:0] dbnc;
    logic [DBNC_W-1:0] cnt;
    logic              reload;
    logic              tick;
    logic [WIDTH-1:0]  samp;
    logic [WIDTH-1:0]  stable;
    logic [WIDTH-1:0]  stable_nxt;
    logic [WIDTH-1:0]  agree;

    assign tick    = (cnt == '0);
    assign dbnc_rd = BUS_W'(dbnc);

    // DBNC register; any write to it restarts the prescaler one cycle later.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dbnc   <= '0;
            reload <= 1'b0;
        end else begin
            reload <= wr && (reg_adr == A_DBNC);
            if (wr && (reg_adr == A_DBNC)) begin
                dbnc <= DBNC_W'((BUS_W'(dbnc) & ~lane_mask) | (wb.dat_i & lane_mask));
            end
        end
    end

    // Prescaler: down-counter, tick while zero, period DBNC+1.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt <= '0;
        end else if (reload || tick) begin
            cnt <= dbnc;
        end else begin
            cnt <= cnt - DBNC_W'(1);
        end
    end

    // samp is taken alongside the second sync stage so that a level seen at
    // two consecutive ticks is accepted on the second one.
    always_comb begin
        agree      = ~(sync ^ samp);
        stable_nxt = stable;
        if (tick) begin
            stable_nxt = (stable & ~agree) | (sync & agree);
        end
    end

    // Debounce state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            samp   <= '0;
            stable <= '0;
        end else begin
            if (tick) begin
                samp <= sync1;
            end
            stable <= stable_nxt;
        end
    end

    assign level = stable;
    assign rise  = stable_nxt & ~stable;
    assign fall  = ~stable_nxt & stable;
`else
    logic [WIDTH-1:0] stable_q;

    assign dbnc_rd = BUS_W'({DBNC_W{1'b0}});

    // Previous synchronised level for edge detection.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stable_q <= '0;
        end else begin
            stable_q <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~stable_q;
    assign fall  = ~sync & stable_q;
`endif

    // Events to latch and W1C clears for this cycle.
    always_comb begin
        set_bits = (rise & rise_en) | (fall & fall_en);
        clr_bits = '0;
        if (wr && (reg_adr == A_STATUS)) begin
            clr_bits = WIDTH'(wb.dat_i & lane_mask);
        end
    end

    // Enable registers, status (set wins over clear) and the interrupt.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rise_en <= '0;
            fall_en <= '0;
            status  <= '0;
            irq_o   <= 1'b0;
        end else begin
            if (wr && (reg_adr == A_RISE_EN)) begin
                rise_en <= WIDTH'((BUS_W'(rise_en) & ~lane_mask) | (wb.dat_i & lane_mask));
            end
            if (wr && (reg_adr == A_FALL_EN)) begin
                fall_en <= WIDTH'((BUS_W'(fall_en) & ~lane_mask) | (wb.dat_i & lane_mask));
            end
            status <= (status & ~clr_bits) | set_bits;
            irq_o  <= |status;
        end
    end

    // Read mux, zero-extended; unmapped addresses read zero.
    always_comb begin
        rd_data = '0;
        case (reg_adr)
            A_LEVEL:   rd_data = BUS_W'(level);
            A_RISE_EN: rd_data = BUS_W'(rise_en);
            A_FALL_EN: rd_data = BUS_W'(fall_en);
            A_STATUS:  rd_data = BUS_W'(status);
            A_DBNC:    rd_data = dbnc_rd;
            default:   rd_data = '0;
        endcase
    end

    // Registered ack and read data.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wb.ack_o <= 1'b0;
            wb.dat_o <= '0;
        end else begin
            wb.ack_o <= acc;
            if (acc) begin
                wb.dat_o <= rd_data;
            end
        end
    end
endmodule
